// File: rtl/quidditch_pkg.sv
// Shared playfield geometry, default radii and ball direction type for the
// quidditch game blocks.
package quidditch_pkg;

  localparam int FIELD_WIDTH           = 640;
  localparam int FIELD_HEIGHT          = 480;
  localparam int PLAYER_X_OFFSET       = 32;
  localparam int CENTRE_X              = 320;
  localparam int CENTRE_Y              = 240;
  localparam int DEFAULT_PLAYER_RADIUS = 16;
  localparam int DEFAULT_BALL_RADIUS   = 8;
  localparam int DEFAULT_GOAL_RADIUS   = 48;

  localparam int POS_W     = 10;
  localparam int POS_OUT_W = 19;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_t;

  // |a - b| through an 11-bit signed intermediate.
  function automatic logic [POS_W:0] abs_diff(input pos_t a, input pos_t b);
    logic signed [POS_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[POS_W] ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/ball_controller_if.sv
// Signal bundle between the game controller and the ball controller.
interface ball_controller_if;
  import quidditch_pkg::*;

  logic                 game_over;
  logic [POS_W-1:0]     team1_ver_position;
  logic [POS_W-1:0]     team2_ver_position;
  logic                 team1_vu_button;
  logic                 team1_vd_button;
  logic                 team2_vu_button;
  logic                 team2_vd_button;
  logic                 team1_hl_button;
  logic                 team1_hr_button;
  logic                 team2_hl_button;
  logic                 team2_hr_button;
  logic                 score_to_team1;
  logic                 score_to_team2;
  logic [POS_OUT_W-1:0] x_position;
  logic [POS_OUT_W-1:0] y_position;
  logic                 game_on;

  modport master (
    output game_over, team1_ver_position, team2_ver_position,
    output team1_vu_button, team1_vd_button, team2_vu_button, team2_vd_button,
    output team1_hl_button, team1_hr_button, team2_hl_button, team2_hr_button,
    input  score_to_team1, score_to_team2, x_position, y_position, game_on
  );

  modport slave (
    input  game_over, team1_ver_position, team2_ver_position,
    input  team1_vu_button, team1_vd_button, team2_vu_button, team2_vd_button,
    input  team1_hl_button, team1_hr_button, team2_hl_button, team2_hr_button,
    output score_to_team1, score_to_team2, x_position, y_position, game_on
  );

endinterface

// File: rtl/move_tick_gen.sv
// Ball movement divider: one tick every PERIOD enabled cycles; the count
// holds while enable is low so a paused game resumes mid-period.
module move_tick_gen #(
  parameter int PERIOD = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = enable && (cnt_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/ball_controller.sv
// Ball motion, wall/paddle bounces and goal detection for the playfield;
// the only control state is the {dir_x, dir_y} pair.
module ball_controller
  import quidditch_pkg::*;
#(
  parameter int PLAYER_RADIUS      = DEFAULT_PLAYER_RADIUS,
  parameter int BALL_RADIUS        = DEFAULT_BALL_RADIUS,
  parameter int GOAL_RADIUS        = DEFAULT_GOAL_RADIUS,
  parameter int MOVEMENT_FREQUENCY = 250000
) (
  input logic               clk,
  input logic               rst,
  ball_controller_if.slave  bus
);

  localparam pos_t X_START    = pos_t'(CENTRE_X);
  localparam pos_t Y_START    = pos_t'(CENTRE_Y);
  localparam pos_t X_MIN      = pos_t'(BALL_RADIUS);
  localparam pos_t X_MAX      = pos_t'(FIELD_WIDTH - 1 - BALL_RADIUS);
  localparam pos_t Y_MIN      = pos_t'(BALL_RADIUS);
  localparam pos_t Y_MAX      = pos_t'(FIELD_HEIGHT - 1 - BALL_RADIUS);
  localparam pos_t X_HIT_T1   = pos_t'(PLAYER_X_OFFSET + PLAYER_RADIUS + BALL_RADIUS);
  localparam pos_t X_HIT_T2   = pos_t'(FIELD_WIDTH - 1 - PLAYER_X_OFFSET - PLAYER_RADIUS - BALL_RADIUS);
  localparam logic [POS_W:0] REACH     = (POS_W+1)'(PLAYER_RADIUS + BALL_RADIUS);
  localparam logic [POS_W:0] GOAL_HALF = (POS_W+1)'(GOAL_RADIUS);

  pos_t x_reg, x_next;
  pos_t y_reg, y_next;
  dir_t dir_x_reg, dir_x_next;
  dir_t dir_y_reg, dir_y_next;
  logic game_on_reg;
  logic score1_reg, score1_next;
  logic score2_reg, score2_next;
  logic tick;
  logic any_button;
  logic in_goal;
  logic hit_t1, hit_t2;

  assign any_button = |{bus.team1_vu_button, bus.team1_vd_button,
                        bus.team2_vu_button, bus.team2_vd_button,
                        bus.team1_hl_button, bus.team1_hr_button,
                        bus.team2_hl_button, bus.team2_hr_button};

  move_tick_gen #(
    .PERIOD (MOVEMENT_FREQUENCY)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (game_on_reg && !bus.game_over),
    .tick   (tick)
  );

  assign in_goal = abs_diff(y_reg, Y_START) <= GOAL_HALF;
  assign hit_t2  = (dir_x_reg == DIR_POS) && (x_reg == X_HIT_T2) &&
                   (abs_diff(y_reg, bus.team2_ver_position) <= REACH);
  assign hit_t1  = (dir_x_reg == DIR_NEG) && (x_reg == X_HIT_T1) &&
                   (abs_diff(y_reg, bus.team1_ver_position) <= REACH);

  always_comb begin
    x_next      = x_reg;
    y_next      = y_reg;
    dir_x_next  = dir_x_reg;
    dir_y_next  = dir_y_reg;
    score1_next = 1'b0;
    score2_next = 1'b0;
    if (tick) begin
      if (dir_y_reg == DIR_NEG && y_reg <= Y_MIN) begin
        dir_y_next = DIR_POS;
        y_next     = y_reg + pos_t'(1);
      end else if (dir_y_reg == DIR_POS && y_reg >= Y_MAX) begin
        dir_y_next = DIR_NEG;
        y_next     = y_reg - pos_t'(1);
      end else begin
        y_next = (dir_y_reg == DIR_POS) ? y_reg + pos_t'(1) : y_reg - pos_t'(1);
      end

      // A bounce flips dir_x and steps once in the new direction.
      if (hit_t2 || (dir_x_reg == DIR_POS && x_reg >= X_MAX && !in_goal)) begin
        dir_x_next = DIR_NEG;
        x_next     = x_reg - pos_t'(1);
      end else if (hit_t1 || (dir_x_reg == DIR_NEG && x_reg <= X_MIN && !in_goal)) begin
        dir_x_next = DIR_POS;
        x_next     = x_reg + pos_t'(1);
      end else if (dir_x_reg == DIR_POS && x_reg >= X_MAX) begin
        score1_next = 1'b1;
        x_next      = X_START;
        y_next      = Y_START;
        dir_x_next  = DIR_NEG;
        dir_y_next  = DIR_POS;
      end else if (dir_x_reg == DIR_NEG && x_reg <= X_MIN) begin
        score2_next = 1'b1;
        x_next      = X_START;
        y_next      = Y_START;
        dir_x_next  = DIR_POS;
        dir_y_next  = DIR_POS;
      end else begin
        x_next = (dir_x_reg == DIR_POS) ? x_reg + pos_t'(1) : x_reg - pos_t'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg       <= X_START;
      y_reg       <= Y_START;
      dir_x_reg   <= DIR_POS;
      dir_y_reg   <= DIR_POS;
      game_on_reg <= 1'b0;
      score1_reg  <= 1'b0;
      score2_reg  <= 1'b0;
    end else begin
      x_reg       <= x_next;
      y_reg       <= y_next;
      dir_x_reg   <= dir_x_next;
      dir_y_reg   <= dir_y_next;
      game_on_reg <= game_on_reg | any_button;
      score1_reg  <= score1_next;
      score2_reg  <= score2_next;
    end
  end

  assign bus.x_position     = {{(POS_OUT_W-POS_W){1'b0}}, x_reg};
  assign bus.y_position     = {{(POS_OUT_W-POS_W){1'b0}}, y_reg};
  assign bus.game_on        = game_on_reg;
  assign bus.score_to_team1 = score1_reg;
  assign bus.score_to_team2 = score2_reg;

endmodule

// File: tb/tb_ball_controller.sv
// Directed bench: three ball controllers (paddle bounce, edge bounce, wide goal)
// share clock, reset and buttons and differ in paddle position / goal size.
module tb_ball_controller;

  logic       clk;
  logic       rst;
  logic       game_over;
  logic [7:0] btn;
  int         checks;
  int         failures;
  int         cyc;

  ball_controller_if ifa ();
  ball_controller_if ifb ();
  ball_controller_if ifc ();

  assign ifa.game_over = game_over;
  assign ifb.game_over = game_over;
  assign ifc.game_over = game_over;
  assign ifa.team1_ver_position = 10'd240;
  assign ifb.team1_ver_position = 10'd240;
  assign ifc.team1_ver_position = 10'd240;
  assign ifa.team2_ver_position = 10'd439;
  assign ifb.team2_ver_position = 10'd100;
  assign ifc.team2_ver_position = 10'd100;
  assign {ifa.team2_hr_button, ifa.team2_hl_button, ifa.team1_hr_button, ifa.team1_hl_button,
          ifa.team2_vd_button, ifa.team2_vu_button, ifa.team1_vd_button, ifa.team1_vu_button} = btn;
  assign {ifb.team2_hr_button, ifb.team2_hl_button, ifb.team1_hr_button, ifb.team1_hl_button,
          ifb.team2_vd_button, ifb.team2_vu_button, ifb.team1_vd_button, ifb.team1_vu_button} = btn;
  assign {ifc.team2_hr_button, ifc.team2_hl_button, ifc.team1_hr_button, ifc.team1_hl_button,
          ifc.team2_vd_button, ifc.team2_vu_button, ifc.team1_vd_button, ifc.team1_vu_button} = btn;

  ball_controller #(.MOVEMENT_FREQUENCY(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  ball_controller #(.MOVEMENT_FREQUENCY(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  ball_controller #(.MOVEMENT_FREQUENCY(4), .GOAL_RADIUS(200)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance to the negedge following move tick n (one tick per 4 cycles).
  task automatic to_tick(input int n);
    while (cyc < 4 * n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    rst       = 1'b1;
    game_over = 1'b0;
    btn       = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_x", ifa.x_position, 320);
    check("idle_y", ifa.y_position, 240);
    check("idle_game_on", ifa.game_on, 0);
    check("idle_score1", ifa.score_to_team1, 0);
    $display("step idle: x=%0d y=%0d game_on=%0d", ifa.x_position, ifa.y_position, ifa.game_on);

    btn[0] = 1'b1;
    @(negedge clk);
    btn[0] = 1'b0;
    cyc = 0;
    check("start_game_on", ifa.game_on, 1);
    $display("step start: game_on=%0d", ifa.game_on);

    to_tick(1);
    check("t1_x", ifa.x_position, 321);
    check("t1_y", ifa.y_position, 241);
    $display("step tick1: x=%0d y=%0d", ifa.x_position, ifa.y_position);

    to_tick(231);
    check("t231_x", ifa.x_position, 551);
    check("t231_y", ifa.y_position, 471);
    to_tick(232);
    check("t232_x", ifa.x_position, 552);
    check("t232_y_bounce", ifa.y_position, 470);
    $display("step bottom bounce: x=%0d y=%0d", ifa.x_position, ifa.y_position);

    to_tick(263);
    check("t263_a_x", ifa.x_position, 583);
    check("t263_a_y", ifa.y_position, 439);
    check("t263_b_x", ifb.x_position, 583);
    to_tick(264);
    check("t264_a_x_paddle", ifa.x_position, 582);
    check("t264_a_y", ifa.y_position, 438);
    check("t264_b_x_miss", ifb.x_position, 584);
    $display("step paddle: a_x=%0d b_x=%0d", ifa.x_position, ifb.x_position);

    to_tick(311);
    check("t311_b_x", ifb.x_position, 631);
    check("t311_b_y", ifb.y_position, 391);
    check("t311_c_x", ifc.x_position, 631);
    to_tick(312);
    check("t312_b_x_edge", ifb.x_position, 630);
    check("t312_b_y", ifb.y_position, 390);
    check("t312_b_score1", ifb.score_to_team1, 0);
    check("t312_b_score2", ifb.score_to_team2, 0);
    check("t312_c_score1", ifc.score_to_team1, 1);
    check("t312_c_score2", ifc.score_to_team2, 0);
    check("t312_c_x", ifc.x_position, 320);
    check("t312_c_y", ifc.y_position, 240);
    check("t312_a_x", ifa.x_position, 534);
    $display("step goal: b_x=%0d c_score1=%0d c_x=%0d c_y=%0d",
             ifb.x_position, ifc.score_to_team1, ifc.x_position, ifc.y_position);
    @(negedge clk);
    cyc++;
    check("goal_pulse_width", ifc.score_to_team1, 0);

    to_tick(313);
    check("t313_c_x", ifc.x_position, 319);
    check("t313_c_y", ifc.y_position, 241);
    check("t313_b_x", ifb.x_position, 629);
    check("t313_b_y", ifb.y_position, 389);
    $display("step after goal: c_x=%0d c_y=%0d", ifc.x_position, ifc.y_position);

    to_tick(320);
    check("t320_a_x", ifa.x_position, 526);
    check("t320_a_y", ifa.y_position, 382);
    game_over = 1'b1;
    repeat (4) @(negedge clk);
    check("freeze4_a_x", ifa.x_position, 526);
    repeat (396) @(negedge clk);
    check("freeze400_a_x", ifa.x_position, 526);
    check("freeze400_a_y", ifa.y_position, 382);
    check("freeze400_c_x", ifc.x_position, 312);
    check("freeze400_c_y", ifc.y_position, 248);
    $display("step freeze: a_x=%0d a_y=%0d", ifa.x_position, ifa.y_position);
    game_over = 1'b0;
    repeat (3) @(negedge clk);
    check("resume3_a_x", ifa.x_position, 526);
    @(negedge clk);
    check("resume_a_x", ifa.x_position, 525);
    check("resume_a_y", ifa.y_position, 381);
    check("resume_c_x", ifc.x_position, 311);
    $display("step resume: a_x=%0d a_y=%0d", ifa.x_position, ifa.y_position);

    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_x", ifa.x_position, 320);
    check("async_rst_y", ifa.y_position, 240);
    check("async_rst_game_on", ifa.game_on, 0);
    check("async_rst_c_x", ifc.x_position, 320);
    $display("step async reset: x=%0d y=%0d game_on=%0d", ifa.x_position, ifa.y_position, ifa.game_on);

    game_over = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    btn[6] = 1'b1;
    @(negedge clk);
    btn[6] = 1'b0;
    check("over_game_on", ifa.game_on, 1);
    repeat (20) @(negedge clk);
    check("over_x_held", ifa.x_position, 320);
    check("over_y_held", ifa.y_position, 240);
    $display("step start while over: game_on=%0d x=%0d", ifa.game_on, ifa.x_position);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
